vx_nc_responder: RTL
====================

VX_NC_RESPONDER -- requirements
Module: VX_nc_responder

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 32: memory request address width, in words.
REQ-002 SHALL have parameter MEM_DATA_SIZE, default 4: data word size in bytes; MEM_DATA_WIDTH = MEM_DATA_SIZE*8.
REQ-003 SHALL have parameter MEM_TAG_WIDTH, default 8: request/response tag width.
REQ-004 SHALL have parameter NUM_WORDS, default 16: local storage depth; power of two, >= 2.
REQ-005 SHALL have parameter LATENCY, default 2: read accept-to-response latency in cycles; >= 1.
REQ-006 SHALL have parameter RSP_QUEUE_SIZE, default 4: maximum outstanding reads; power of two, >= 2.
REQ-007 Ports, name direction width meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1=write, 0=read.
- mem_req_addr  in  MEM_ADDR_WIDTH  word address.
- mem_req_byteen  in  MEM_DATA_SIZE  write byte enables.
- mem_req_data  in  MEM_DATA_WIDTH  write data.
- mem_req_tag  in  MEM_TAG_WIDTH  request tag.
- mem_req_ready  out  1  request accepted when valid&&ready.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  MEM_DATA_WIDTH  read data.
- mem_rsp_tag  out  MEM_TAG_WIDTH  tag of the originating read.
- mem_rsp_ready  in  1  response consumed when valid&&ready.

Function
REQ-008 Acts as the memory-side endpoint of the non-cacheable request path; holds NUM_WORDS words of storage.
REQ-009 Word index = mem_req_addr[log2(NUM_WORDS)-1:0]; upper address bits ignored (aliasing).
REQ-010 Accepted write: each byte b with byteen[b]=1 updated at the accepting edge; other bytes unchanged; no response generated.
REQ-011 Accepted read: data sampled from storage at the accepting edge, reflecting all writes accepted at earlier edges.
REQ-012 Read response appears on mem_rsp_valid exactly LATENCY cycles after the accepting edge when no backpressure is present; later only if the response queue head is stalled.
REQ-013 Responses returned strictly in request-acceptance order with unmodified tag.
REQ-014 Read pipeline (LATENCY stages) feeds an in-order response queue of depth RSP_QUEUE_SIZE; mem_rsp_* driven from queue head; mem_rsp_valid = queue non-empty.
REQ-015 Outstanding counter: +1 on read accept, -1 on response fire; simultaneous accept and fire leaves it unchanged; writes do not affect it.
REQ-016 mem_req_ready = (outstanding < RSP_QUEUE_SIZE) && !reset; ready derived from registered state only, with no combinational path from mem_rsp_ready or mem_req_valid.
REQ-017 Writes are also blocked while ready=0 (single shared handshake).
REQ-018 Queue can never overflow; pipeline stages never stall (credit guarantees space).
REQ-019 mem_rsp_data/tag held stable while mem_rsp_valid=1 and mem_rsp_ready=0.

Reset
REQ-020 Reset asserted asynchronously clears pipeline valids, queue pointers and outstanding counter; mem_rsp_valid=0 and mem_req_ready=0 immediately.
REQ-021 In-flight reads are discarded on reset; no response is emitted for them.
REQ-022 Storage contents are not reset; mem_rsp_data/tag are don't-care while mem_rsp_valid=0.
REQ-023 mem_req_ready=1 in the first cycle after reset deasserts.

Verification (NUM_WORDS=16, LATENCY=2, RSP_QUEUE_SIZE=4, MEM_DATA_SIZE=4)
REQ-024 Write addr 3, data 0xDEADBEEF, byteen 0xF; read addr 3, tag 0x05 -> rsp valid 2 cycles after read accept, data 0xDEADBEEF, tag 0x05.
REQ-025 Then write addr 3, data 0x00001234, byteen 0x3; read addr 0x13 -> data 0xDEAD1234 (partial write plus alias).
REQ-026 mem_rsp_ready=0; issue 5 back-to-back reads tags 1..5 -> 4 accepted, ready=0 on the 5th; raise rsp_ready -> tags 1,2,3,4 in order, then the 5th is accepted.
REQ-027 At outstanding=3, read accept and response fire in the same cycle -> outstanding stays 3, ready stays 1.
REQ-028 Assert reset mid-cycle with 3 reads outstanding -> rsp_valid and ready drop without a clock edge; after deassert, no stale responses and ready=1.

Source files
------------

// File: rtl/vx_nc_responder.sv
// Memory-side endpoint for non-cacheable requests: word storage, fixed-latency reads and in-order responses.
// Ready comes only from the outstanding-read credit count, so the response queue can never overflow.

module vx_nc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Head is read straight from storage, so it stays stable until popped.
  assign pop_dat = entries[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
endmodule

module vx_nc_responder #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_DATA_SIZE  = 4,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int NUM_WORDS      = 16,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  localparam int MEM_DATA_WIDTH = MEM_DATA_SIZE * 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_rw,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic [MEM_DATA_SIZE-1:0]  mem_req_byteen,
  input  logic [MEM_DATA_WIDTH-1:0] mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]  mem_req_tag,
  output logic                      mem_req_ready,
  output logic                      mem_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0] mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag,
  input  logic                      mem_rsp_ready
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE) + 1;

  typedef struct packed {
    logic [MEM_TAG_WIDTH-1:0]  tag;
    logic [MEM_DATA_WIDTH-1:0] data;
  } rsp_t;

  logic [MEM_DATA_WIDTH-1:0] storage [NUM_WORDS];
  logic [IDX_W-1:0]          word_idx;
  logic                      unused_addr_bits;

  logic             req_fire;
  logic             wr_fire;
  logic             rd_fire;
  logic             rsp_fire;
  logic [CNT_W-1:0] outstanding;

  logic [LATENCY-1:0] pipe_vld;
  rsp_t               pipe_dat [LATENCY];
  rsp_t               q_head;
  logic               q_empty;

  // Upper address bits alias onto the same words.
  assign word_idx         = mem_req_addr[IDX_W-1:0];
  assign unused_addr_bits = ^mem_req_addr[MEM_ADDR_WIDTH-1:IDX_W];

  assign req_fire = mem_req_valid && mem_req_ready;
  assign wr_fire  = req_fire && mem_req_rw;
  assign rd_fire  = req_fire && !mem_req_rw;
  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    for (int b = 0; b < MEM_DATA_SIZE; b++) begin
      if (wr_fire && mem_req_byteen[b]) begin
        storage[word_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Read data is captured at the accepting edge; later stages just carry it along.
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      pipe_dat[0] <= '{tag: mem_req_tag, data: storage[word_idx]};
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  vx_nc_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_QUEUE_SIZE)
  ) u_rsp_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_vld[LATENCY-1]),
    .push_dat (pipe_dat[LATENCY-1]),
    .pop      (rsp_fire),
    .pop_dat  (q_head),
    .empty    (q_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign mem_req_ready = (outstanding < CNT_W'(RSP_QUEUE_SIZE)) && !reset;
  assign mem_rsp_valid = !q_empty;
  assign mem_rsp_data  = q_head.data;
  assign mem_rsp_tag   = q_head.tag;
endmodule
